manchester_tx: RTL and testbench

//  Byte-serial Manchester-code transmitter with a gapless, double-buffered parallel interface.

---
 rtl/mx_pkg.sv | 16 +
 rtl/manchester_tx_if.sv | 28 ++
 rtl/rate_enable.sv | 36 +++
 rtl/manchester_tx.sv | 145 ++++++++++++++
 tb/tb_manchester_tx.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mx_pkg.sv
// Shared Manchester link definitions: transmitter FSM states and half-bit timing helper.
package mx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        EOF
    } mx_tx_state_t;

    // Clocks per half bit period; callers must keep the result >= 2.
    function automatic int unsigned mx_half_bit(input int unsigned clk_freq,
                                                input int unsigned bit_rate);
        return clk_freq / (2 * bit_rate);
    endfunction

endpackage

// File: rtl/manchester_tx_if.sv
// Parallel byte interface plus serial line outputs of the Manchester transmitter.
interface manchester_tx_if;

    logic       send;
    logic [7:0] data;
    logic       ready;
    logic       txd;
    logic       txen;

    // Byte source / line monitor side.
    modport master (
        output send,
        output data,
        input  ready,
        input  txd,
        input  txen
    );

    // Transmitter side.
    modport slave (
        input  send,
        input  data,
        output ready,
        output txd,
        output txen
    );

endinterface

// File: rtl/rate_enable.sv
// Free-running divider producing a one-cycle tick every DIVIDE clocks; clr restarts the count.
module rate_enable #(
    parameter int unsigned DIVIDE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Tick on the last clock of each period.
    assign tick = (cnt_q == CNT_LAST);

    // Next count: restart on clear or at the end of a period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/manchester_tx.sv
// Byte-serial Manchester transmitter with a holding buffer for gapless back-to-back bytes.
module manchester_tx
    import mx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BIT_RATE = 50_000,
    parameter int unsigned EOF_BITS = 2
) (
    input logic            clk,
    input logic            reset,
    manchester_tx_if.slave bus
);

    localparam int unsigned HALF_BIT = mx_half_bit(CLK_FREQ, BIT_RATE);
    localparam int unsigned EOF_LEN  = EOF_BITS * 2 * HALF_BIT;
    localparam int unsigned EOF_W    = (EOF_LEN > 1) ? $clog2(EOF_LEN) : 1;
    localparam logic [EOF_W-1:0] EOF_LAST = EOF_W'(EOF_LEN - 1);

    mx_tx_state_t     state_q, state_d;
    logic [7:0]       hbuf_q, hbuf_d;
    logic             hfull_q, hfull_d;
    logic             ready_q, ready_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       hidx_q, hidx_d;
    logic [EOF_W-1:0] eof_cnt_q, eof_cnt_d;
    logic             txd_q, txd_d;
    logic             txen_q, txen_d;
    logic             accept;
    logic             load;
    logic             tick;
    logic             tmr_clr;

    assign accept  = bus.send && ready_q;
    // Half-bit timer only runs in SEND and restarts on every shifter load.
    assign tmr_clr = (state_q != SEND) || load;

    rate_enable #(
        .DIVIDE (HALF_BIT)
    ) u_rate_enable (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .tick  (tick)
    );

    // FSM next state, shifter load/shift, half-bit index and EOF length counter.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        hidx_d    = hidx_q;
        eof_cnt_d = '0;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hfull_q) begin
                    load    = 1'b1;
                    shift_d = hbuf_q;
                    hidx_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tick) begin
                    if (hidx_q == 4'd15) begin
                        hidx_d = '0;
                        // Only a byte already buffered continues the frame without a gap.
                        if (hfull_q) begin
                            load    = 1'b1;
                            shift_d = hbuf_q;
                        end else begin
                            state_d = EOF;
                        end
                    end else begin
                        hidx_d = hidx_q + 4'd1;
                        if (hidx_q[0]) begin
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end
                end
            end
            EOF: begin
                if (eof_cnt_q == EOF_LAST) begin
                    state_d = IDLE;
                end else begin
                    eof_cnt_d = eof_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding buffer: fill on accept, drain on shifter load (never both in one cycle).
    always_comb begin
        hbuf_d  = hbuf_q;
        hfull_d = hfull_q;
        if (accept) begin
            hbuf_d  = bus.data;
            hfull_d = 1'b1;
        end else if (load) begin
            hfull_d = 1'b0;
        end
        ready_d = ~hfull_d;
    end

    // Line outputs, one register stage behind the FSM: ~b in the first half, b in the second.
    always_comb begin
        txen_d = (state_q != IDLE);
        txd_d  = 1'b1;
        if (state_q == SEND) begin
            txd_d = hidx_q[0] ? shift_q[0] : ~shift_q[0];
        end
    end

    // State registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hbuf_q    <= '0;
            hfull_q   <= 1'b0;
            ready_q   <= 1'b1;
            shift_q   <= '0;
            hidx_q    <= '0;
            eof_cnt_q <= '0;
            txd_q     <= 1'b1;
            txen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hbuf_q    <= hbuf_d;
            hfull_q   <= hfull_d;
            ready_q   <= ready_d;
            shift_q   <= shift_d;
            hidx_q    <= hidx_d;
            eof_cnt_q <= eof_cnt_d;
            txd_q     <= txd_d;
            txen_q    <= txen_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.txd   = txd_q;
    assign bus.txen  = txen_q;

endmodule

// File: tb/tb_manchester_tx.sv
// Self-checking bench for manchester_tx: waveform-level reference model of each frame.
module tb_manchester_tx;

    localparam int HALF      = 5;
    localparam int BIT_CLKS  = 2 * HALF;
    localparam int BYTE_CLKS = 8 * BIT_CLKS;
    localparam int EOF_CLKS  = 2 * BIT_CLKS;
    localparam int MAX_FRAME = 4000;

    logic clk = 1'b0;
    logic reset;

    manchester_tx_if bus_if ();

    manchester_tx #(
        .CLK_FREQ (100_000_000),
        .BIT_RATE (10_000_000),
        .EOF_BITS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       exp_q[$];
    logic       cap_q[$];
    logic [7:0] src_q[$];
    bit         cap_ok;

    // Reference waveform: each bit is HALF samples of ~b then HALF samples of b, LSB first.
    function automatic void model_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < HALF; k++) exp_q.push_back(~b[i]);
            for (int k = 0; k < HALF; k++) exp_q.push_back(b[i]);
        end
    endfunction

    function automatic void model_eof();
        for (int k = 0; k < EOF_CLKS; k++) exp_q.push_back(1'b1);
    endfunction

    // Index of first difference between captured and expected waveforms, -1 if identical.
    function automatic int first_diff();
        int n;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (cap_q[i] !== exp_q[i]) return i;
        end
        if (cap_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Independent decoder: sample mid second half of every bit and compare to src_q.
    function automatic int decode_errors();
        int nb;
        int errs;
        logic [7:0] b;
        errs = 0;
        nb = (cap_q.size() < EOF_CLKS) ? 0 : (cap_q.size() - EOF_CLKS) / BYTE_CLKS;
        if (nb != src_q.size()) errs++;
        for (int j = 0; j < nb && j < src_q.size(); j++) begin
            for (int i = 0; i < 8; i++) b[i] = cap_q[(j * 8 + i) * BIT_CLKS + HALF + HALF / 2];
            if (b !== src_q[j]) errs++;
        end
        return errs;
    endfunction

    // Wait (bounded) for txen, then record txd every clock while txen stays high.
    task automatic capture_frame(input int budget);
        int waited;
        waited = 0;
        cap_q.delete();
        cap_ok = 1'b0;
        while (bus_if.txen !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (bus_if.txen !== 1'b1) return;
        while (bus_if.txen === 1'b1 && cap_q.size() < MAX_FRAME) begin
            cap_q.push_back(bus_if.txd);
            @(negedge clk);
        end
        cap_ok = (bus_if.txen === 1'b0);
    endtask

    // Offer one byte for exactly one clock once ready is seen (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        while (bus_if.ready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        bus_if.send = 1'b1;
        bus_if.data = b;
        @(negedge clk);
        bus_if.send = 1'b0;
    endtask

    task automatic feed_src();
        for (int i = 0; i < src_q.size(); i++) send_byte(src_q[i]);
    endtask

    task automatic wait_txen_rise();
        int waited;
        waited = 0;
        while (bus_if.txen !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.send = 1'b0;
        bus_if.data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus_if.ready);
        end
        n_tests++;
        if (bus_if.txd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_txd: got %b want 1", bus_if.txd);
        end
        n_tests++;
        if (bus_if.txen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_txen: got %b want 0", bus_if.txen);
        end
    endtask

    task automatic test_single();
        int d;
        bus_if.send = 1'b1;
        bus_if.data = 8'hA5;
        @(negedge clk);
        bus_if.send = 1'b0;
        n_tests++;
        if (bus_if.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_low: got %b want 0", bus_if.ready);
        end
        @(negedge clk);
        n_tests++;
        if (bus_if.ready !== 1'b1 || bus_if.txen !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_back: got ready=%b txen=%b want ready=1 txen=0",
                     bus_if.ready, bus_if.txen);
        end
        @(negedge clk);
        n_tests++;
        if (bus_if.txen !== 1'b1) begin
            n_fail++;
            $display("FAIL single_txen_latency: got %b want 1 two clocks after accept",
                     bus_if.txen);
        end
        exp_q.delete();
        model_byte(8'hA5);
        model_eof();
        capture_frame(0);
        d = first_diff();
        n_tests++;
        if (!cap_ok || d != -1) begin
            n_fail++;
            $display("FAIL single_wave: got %0d samples (first diff %0d) want %0d samples",
                     cap_q.size(), d, exp_q.size());
        end
        n_tests++;
        if (bus_if.txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle_txd: got %b want 1", bus_if.txd);
        end
    endtask

    task automatic test_stream();
        int d;
        int e;
        src_q.delete();
        exp_q.delete();
        for (int i = 0; i < 32; i++) src_q.push_back(8'hAA + 8'(i));
        foreach (src_q[i]) model_byte(src_q[i]);
        model_eof();
        fork
            feed_src();
            capture_frame(20);
        join
        n_tests++;
        if (cap_q.size() != 32 * BYTE_CLKS + EOF_CLKS) begin
            n_fail++;
            $display("FAIL stream_txen_len: got %0d clocks want %0d",
                     cap_q.size(), 32 * BYTE_CLKS + EOF_CLKS);
        end
        d = first_diff();
        n_tests++;
        if (!cap_ok || d != -1) begin
            n_fail++;
            $display("FAIL stream_wave: first diff at sample %0d want none", d);
        end
        e = decode_errors();
        n_tests++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL stream_decode: got %0d byte errors want 0", e);
        end
    endtask

    task automatic test_ignore_busy();
        int d;
        logic [7:0] x;
        logic [7:0] y;
        x = 8'($urandom);
        y = 8'($urandom_range(0, 254));
        exp_q.delete();
        model_byte(x);
        model_byte(y);
        model_eof();
        fork
            begin
                send_byte(x);
                send_byte(y);
                bus_if.send = 1'b1;
                bus_if.data = 8'hFF;
                repeat (4) @(negedge clk);
                bus_if.send = 1'b0;
                n_tests++;
                if (bus_if.ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_ready: got %b want 0 while buffer full", bus_if.ready);
                end
            end
            capture_frame(20);
        join
        d = first_diff();
        n_tests++;
        if (!cap_ok || d != -1) begin
            n_fail++;
            $display("FAIL ignore_wave: bytes %h,%h first diff %0d want none", x, y, d);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        logic [7:0] x;
        x = 8'($urandom);
        send_byte(x);
        send_byte(8'($urandom));
        wait_txen_rise();
        repeat (34) @(negedge clk);  // inside bit 3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (bus_if.txd !== 1'b1 || bus_if.txen !== 1'b0 || bus_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: got txd=%b txen=%b ready=%b want 1,0,1",
                     bus_if.txd, bus_if.txen, bus_if.ready);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus_if.txen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_discard: got txen=%b want 0 after reset", bus_if.txen);
        end
        exp_q.delete();
        model_byte(8'h3C);
        model_eof();
        fork
            send_byte(8'h3C);
            capture_frame(20);
        join
        d = first_diff();
        n_tests++;
        if (!cap_ok || d != -1) begin
            n_fail++;
            $display("FAIL midreset_next: first diff %0d want none", d);
        end
    endtask

    // Second byte offered at 'off' clocks after txen rise; 77 streams, 78 is one clock too late.
    task automatic test_eof_and_tick(input int off, input logic [7:0] y, input string tag);
        int d;
        logic [7:0] x;
        x = 8'($urandom);
        exp_q.delete();
        model_byte(x);
        if (off < BYTE_CLKS - 2) model_byte(y);
        model_eof();
        fork
            begin
                send_byte(x);
                wait_txen_rise();
                repeat (off) @(negedge clk);
                send_byte(y);
            end
            begin
                capture_frame(20);
                d = first_diff();
                n_tests++;
                if (!cap_ok || d != -1) begin
                    n_fail++;
                    $display("FAIL %s_frame1: got %0d samples (diff %0d) want %0d", tag,
                             cap_q.size(), d, exp_q.size());
                end
                if (off >= BYTE_CLKS - 2) begin
                    @(negedge clk);
                    n_tests++;
                    if (bus_if.txen !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s_gap: got txen=%b want 1 after one idle clock", tag,
                                 bus_if.txen);
                    end
                    exp_q.delete();
                    model_byte(y);
                    model_eof();
                    capture_frame(0);
                    d = first_diff();
                    n_tests++;
                    if (!cap_ok || d != -1) begin
                        n_fail++;
                        $display("FAIL %s_frame2: got %0d samples (diff %0d) want %0d", tag,
                                 cap_q.size(), d, exp_q.size());
                    end
                end
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_streams();
        int d;
        int e;
        for (int r = 0; r < 3; r++) begin
            src_q.delete();
            exp_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) src_q.push_back(8'($urandom));
            foreach (src_q[i]) model_byte(src_q[i]);
            model_eof();
            fork
                feed_src();
                capture_frame(20);
            join
            d = first_diff();
            e = decode_errors();
            n_tests++;
            if (!cap_ok || d != -1 || e != 0) begin
                n_fail++;
                $display("FAIL random_stream%0d: diff %0d decode errors %0d want -1 and 0",
                         r, d, e);
            end
            repeat (int'($urandom_range(1, 6))) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.send = 1'b0;
        bus_if.data = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        repeat (3) @(negedge clk);
        test_stream();
        repeat (3) @(negedge clk);
        test_ignore_busy();
        repeat (3) @(negedge clk);
        test_reset_mid();
        repeat (3) @(negedge clk);
        test_eof_and_tick(BYTE_CLKS + 5, 8'h01, "eof_accept");
        test_eof_and_tick(BYTE_CLKS - 3, 8'($urandom), "tick_early");
        test_eof_and_tick(BYTE_CLKS - 2, 8'($urandom), "tick_exact");
        test_random_streams();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
